// File: rtl/sim_uart_pkg.sv
// Shared types and timing helpers for the simulation UART bank.
// SIM_UART_PARITY_EN adds the PARITY states to both FSM enums.
package sim_uart_pkg;
    localparam int unsigned DefaultFreq = 30_000_000;
    localparam int unsigned DefaultBaud = 921_600;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SIM_UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef SIM_UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    function automatic int unsigned clocks_per_bit(int unsigned freq, int unsigned baud);
        return freq / baud;
    endfunction
endpackage

// File: rtl/sim_uart_if.sv
// Host-side byte streams of the UART bank: RX FIFO heads out, TX requests in.
interface sim_uart_if #(
    parameter int unsigned NumChannels = 5,
    parameter int unsigned DataBits    = 8
);
    logic [NumChannels-1:0][DataBits-1:0] rx_data;
    logic [NumChannels-1:0]               rx_valid;
    logic [NumChannels-1:0]               rx_ready;
    logic [NumChannels-1:0][DataBits-1:0] tx_data;
    logic [NumChannels-1:0]               tx_valid;
    logic [NumChannels-1:0]               tx_ready;

    modport master (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
    modport slave  (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/sim_uart_chan.sv
// One UART channel: RX deserialiser into a FWFT FIFO, TX serialiser.
// SIM_UART_PARITY_EN inserts an even parity bit in both directions.
module sim_uart_chan
    import sim_uart_pkg::*;
#(
    parameter int unsigned ClocksPerBit = 32,
    parameter int unsigned DataBits     = 8,
    parameter int unsigned RxFifoDepth  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                uart_rx_i,
    output logic                uart_tx_o,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    input  logic [DataBits-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic                rx_overflow_o,
    output logic                rx_frame_err_o,
    output logic                rx_parity_err_o
);
    localparam int unsigned CntW = $clog2(ClocksPerBit);
    localparam int unsigned BitW = $clog2(DataBits);
    localparam int unsigned AW   = $clog2(RxFifoDepth);
    localparam logic [CntW-1:0] CntLast  = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClocksPerBit / 2 - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(DataBits - 1);

    // ---------------- RX ----------------
    logic [1:0]          sync_q;
    logic                rx_s, prev_q;
    rx_state_e           rx_st_q, rx_st_d;
    logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]     rx_bit_q, rx_bit_d;
    logic [DataBits-1:0] rx_shift_q, rx_shift_d;
    logic                push, frame_err;
`ifdef SIM_UART_PARITY_EN
    logic                par_err;
`endif

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx_i};
            prev_q     <= rx_s;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push       = 1'b0;
        frame_err  = 1'b0;
`ifdef SIM_UART_PARITY_EN
        par_err    = 1'b0;
`endif
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !rx_s) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HalfLast) begin
                // A start bit that is high again at mid-bit was only a glitch
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_s) rx_st_d = RX_IDLE;
                else      rx_st_d = RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == CntLast) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[DataBits-1:1]};
                rx_bit_d   = rx_bit_q + BitW'(1);
`ifdef SIM_UART_PARITY_EN
                if (rx_bit_q == BitLast) rx_st_d = RX_PARITY;
`else
                if (rx_bit_q == BitLast) rx_st_d = RX_STOP;
`endif
            end
`ifdef SIM_UART_PARITY_EN
            RX_PARITY: if (rx_cnt_q == CntLast) begin
                rx_cnt_d = '0;
                par_err  = rx_s != ^rx_shift_q;
                rx_st_d  = RX_STOP;
            end
`endif
            RX_STOP: if (rx_cnt_q == CntLast) begin
                rx_cnt_d = '0;
                if (rx_s) begin
                    push    = 1'b1;
                    rx_st_d = RX_IDLE;
                end else begin
                    frame_err = 1'b1;
                    rx_st_d   = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO (first-word fall-through) ----------------
    logic [DataBits-1:0] mem_q [RxFifoDepth];
    logic [AW:0]         wr_q, rd_q;
    logic                empty, full, pop, do_push;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && rx_ready_i;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)     rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= rx_shift_q;
    end

    assign rx_valid_o     = !empty;
    assign rx_data_o      = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign rx_overflow_o  = push && full && !pop;
    assign rx_frame_err_o = frame_err;
`ifdef SIM_UART_PARITY_EN
    assign rx_parity_err_o = par_err;
`else
    assign rx_parity_err_o = 1'b0;
`endif

    // ---------------- TX ----------------
    tx_state_e           tx_st_q, tx_st_d;
    logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]     tx_bit_q, tx_bit_d;
    logic [DataBits-1:0] tx_shift_q, tx_shift_d;
`ifdef SIM_UART_PARITY_EN
    logic                tx_par_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_st_q    <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

`ifdef SIM_UART_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                      tx_par_q <= 1'b0;
        else if (tx_ready_o && tx_valid_i) tx_par_q <= ^tx_data_i;
    end
`endif

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_ready_o = 1'b0;
        uart_tx_o  = 1'b1;
        case (tx_st_q)
            TX_IDLE: begin
                tx_ready_o = 1'b1;
                tx_cnt_d   = '0;
            end
            TX_START: begin
                uart_tx_o = 1'b0;
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                    tx_st_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                uart_tx_o = tx_shift_q[0];
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[DataBits-1:1]};
                    tx_bit_d   = tx_bit_q + BitW'(1);
`ifdef SIM_UART_PARITY_EN
                    if (tx_bit_q == BitLast) tx_st_d = TX_PARITY;
`else
                    if (tx_bit_q == BitLast) tx_st_d = TX_STOP;
`endif
                end
            end
`ifdef SIM_UART_PARITY_EN
            TX_PARITY: begin
                uart_tx_o = tx_par_q;
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    tx_st_d  = TX_STOP;
                end
            end
`endif
            TX_STOP: if (tx_cnt_q == CntLast) begin
                // Ready in the last stop cycle lets frames run back to back
                tx_ready_o = 1'b1;
                tx_cnt_d   = '0;
                tx_st_d    = TX_IDLE;
            end
            default: tx_st_d = TX_IDLE;
        endcase
        if (tx_ready_o && tx_valid_i) begin
            tx_st_d    = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data_i;
        end
    end
endmodule

// File: rtl/sim_uart_bank.sv
// NumChannels independent virtual UARTs for the simulation top level.
// Parity support is enabled with SIM_UART_PARITY_EN.
module sim_uart_bank
    import sim_uart_pkg::*;
#(
    parameter int unsigned NumChannels    = 5,
    parameter int unsigned ClockFrequency = DefaultFreq,
    parameter int unsigned BaudRate       = DefaultBaud,
    parameter int unsigned DataBits       = 8,
    parameter int unsigned RxFifoDepth    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumChannels-1:0] uart_rx_i,
    output logic [NumChannels-1:0] uart_tx_o,
    sim_uart_if.slave              host,
    output logic [NumChannels-1:0] rx_overflow_o,
    output logic [NumChannels-1:0] rx_frame_err_o,
    output logic [NumChannels-1:0] rx_parity_err_o
);
    localparam int unsigned ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);

    if (ClocksPerBit < 4 || DataBits < 5 || DataBits > 9 || RxFifoDepth < 2 ||
        (RxFifoDepth & (RxFifoDepth - 1)) != 0) begin : g_bad_cfg
        $error("sim_uart_bank: unsupported bit timing, data width or FIFO depth");
    end

    logic [NumChannels-1:0][DataBits-1:0] rx_data;
    logic [NumChannels-1:0]               rx_valid, tx_ready;

    assign host.rx_data  = rx_data;
    assign host.rx_valid = rx_valid;
    assign host.tx_ready = tx_ready;

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        sim_uart_chan #(
            .ClocksPerBit(ClocksPerBit),
            .DataBits    (DataBits),
            .RxFifoDepth (RxFifoDepth)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .uart_rx_i      (uart_rx_i[c]),
            .uart_tx_o      (uart_tx_o[c]),
            .rx_data_o      (rx_data[c]),
            .rx_valid_o     (rx_valid[c]),
            .rx_ready_i     (host.rx_ready[c]),
            .tx_data_i      (host.tx_data[c]),
            .tx_valid_i     (host.tx_valid[c]),
            .tx_ready_o     (tx_ready[c]),
            .rx_overflow_o  (rx_overflow_o[c]),
            .rx_frame_err_o (rx_frame_err_o[c]),
            .rx_parity_err_o(rx_parity_err_o[c])
        );
    end
endmodule

// File: tb/tb_sim_uart_bank.sv
// Scoreboard bench for sim_uart_bank: RX pops and TX line frames are checked
// against queues filled by the directed stimulus.
module tb_sim_uart_bank;
    localparam int NCH = 5;
    localparam int DW  = 8;
    localparam int CPB = 32;
`ifdef SIM_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MID_STOP = (FB - 1) * CPB + 16;
    localparam int PUSH_LAT = FB * CPB - 13;

    typedef struct packed { logic [7:0] ch; logic [7:0] d; } rx_item_t;
    typedef struct packed { logic [7:0] d; logic p; } tx_item_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic [NCH-1:0] uart_rx, uart_tx, ovf, ferr, perr;
    logic mon_en = 1'b0;

    sim_uart_if #(.NumChannels(NCH), .DataBits(DW)) bus();

    sim_uart_bank #(
        .NumChannels(NCH), .ClockFrequency(30_000_000), .BaudRate(921_600),
        .DataBits(DW), .RxFifoDepth(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
        .host(bus), .rx_overflow_o(ovf), .rx_frame_err_o(ferr), .rx_parity_err_o(perr)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    int ovf_cnt [NCH];
    int ferr_cnt[NCH];
    int perr_cnt[NCH];
    int pop_cyc [NCH];
    rx_item_t rx_exp[$];
    tx_item_t tx_exp[$];

    initial for (int c = 0; c < NCH; c++) begin
        ovf_cnt[c] = 0; ferr_cnt[c] = 0; perr_cnt[c] = 0; pop_cyc[c] = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mon_en)
        for (int c = 0; c < NCH; c++) begin
            if (ovf[c])  ovf_cnt[c]  <= ovf_cnt[c] + 1;
            if (ferr[c]) ferr_cnt[c] <= ferr_cnt[c] + 1;
            if (perr[c]) perr_cnt[c] <= perr_cnt[c] + 1;
        end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endfunction

    // RX scoreboard: every host pop must match the next expected character
    initial begin : rx_mon
        rx_item_t it;
        forever begin
            @(negedge clk);
            if (mon_en) for (int c = 0; c < NCH; c++)
                if (bus.rx_valid[c] && bus.rx_ready[c]) begin
                    pop_cyc[c] = cyc;
                    if (rx_exp.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rx_unexpected: actual ch%0d data %0h, required no character", c, bus.rx_data[c]);
                    end else begin
                        it = rx_exp.pop_front();
                        check("rx_pop {ch,data}", {c[7:0], bus.rx_data[c]}, {it.ch, it.d});
                    end
                end
        end
    end

    // TX scoreboard: decode channel 0 line at mid-bit
    initial begin : tx_mon
        tx_item_t it;
        logic [7:0] d;
        logic p, stp;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx[0] == 1'b0) begin
                repeat (16) @(negedge clk);
                check("tx_start_mid", uart_tx[0], 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_tx[0];
                end
                p = 1'b0;
`ifdef SIM_UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = uart_tx[0];
`endif
                repeat (CPB) @(negedge clk);
                stp = uart_tx[0];
                if (tx_exp.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL tx_unexpected: actual frame %0h, required no frame", d);
                end else begin
                    it = tx_exp.pop_front();
                    check("tx_frame {stop,parity,data}", {stp, p, d}, {1'b1, it.p, it.d});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input logic p, input logic stp);
        uart_rx[ch] = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rx[ch] = d[i]; tick(CPB); end
`ifdef SIM_UART_PARITY_EN
        uart_rx[ch] = p; tick(CPB);
`endif
        uart_rx[ch] = stp; tick(CPB);
    endtask

    logic [8:0] par_tab = 9'b001101001;  // even parity of 8'h10..8'h18
    int start, lat, tot;

    initial begin
        uart_rx = '0; bus.rx_ready = '1; bus.tx_data = '0; bus.tx_valid = '0;
        #1 rst_ni = 1'b0;
        tick(5);
        check("rst_uart_tx", uart_tx, 5'h1f);
        check("rst_tx_ready", bus.tx_ready, 5'h1f);
        check("rst_rx_valid", bus.rx_valid, 5'h00);
        check("rst_rx_data", bus.rx_data, 40'h0);
        check("rst_err_pulses", {ovf, ferr, perr}, 15'h0);
        rst_ni = 1'b1; mon_en = 1'b1;
        tick(2); uart_rx = '1; tick(60);
        tot = 0; for (int c = 0; c < NCH; c++) tot += ferr_cnt[c];
        check("post_rst_no_char", bus.rx_valid, 5'h00);
        check("post_rst_no_ferr", tot, 0);

        // TX: A5 with ignored request while busy, then 03 back to back
        check("tx_ready_idle", bus.tx_ready[0], 1'b1);
        bus.tx_data[0] = 8'hA5; bus.tx_valid[0] = 1'b1; tx_exp.push_back({8'hA5, 1'b0});
        tick; bus.tx_valid[0] = 1'b0;
        check("tx_start_next_cycle", uart_tx[0], 1'b0);
        check("tx_ready_busy", bus.tx_ready[0], 1'b0);
        bus.tx_data[0] = 8'hFF; bus.tx_valid[0] = 1'b1; tick(5); bus.tx_valid[0] = 1'b0;
        tick(FB * CPB - 7);
        check("tx_ready_before_last_stop", bus.tx_ready[0], 1'b0);
        tick;
        check("tx_ready_last_stop", bus.tx_ready[0], 1'b1);
        check("tx_stop_high", uart_tx[0], 1'b1);
        bus.tx_data[0] = 8'h03; bus.tx_valid[0] = 1'b1; tx_exp.push_back({8'h03, 1'b0});
        tick; bus.tx_valid[0] = 1'b0;
        check("tx_b2b_start", uart_tx[0], 1'b0);
        tick(FB * CPB + 40);

        // RX: 3C on channel 2, latency from frame start
        rx_exp.push_back({8'd2, 8'h3C});
        start = cyc;
        send_frame(2, 8'h3C, 1'b0, 1'b1);
        tick(20);
        lat = pop_cyc[2] - start;
        vectors++;
        if (lat < MID_STOP || lat > MID_STOP + 3) begin
            miscompares++;
            $display("FAIL rx_latency: actual %0d cycles, required %0d..%0d", lat, MID_STOP, MID_STOP + 3);
        end
        check("rx_others_no_ferr", {ferr_cnt[0], ferr_cnt[1], ferr_cnt[3], ferr_cnt[4]}, 128'h0);

        // Overflow on channel 1
        bus.rx_ready[1] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rx_exp.push_back({8'd1, 8'h10 + i[7:0]});
            send_frame(1, 8'h10 + i[7:0], par_tab[i], 1'b1);
        end
        check("ovf_pulse_once", ovf_cnt[1], 1);
        check("ovf_head_held_valid", bus.rx_valid[1], 1'b1);
        check("ovf_head_held_data", bus.rx_data[1], 8'h10);
        rx_exp.push_back({8'd1, 8'h19});
        fork
            send_frame(1, 8'h19, 1'b1, 1'b1);
            begin tick(PUSH_LAT - 1); bus.rx_ready[1] = 1'b1; tick; bus.rx_ready[1] = 1'b0; end
        join
        check("ovf_pop_push_no_pulse", ovf_cnt[1], 1);
        bus.rx_ready[1] = 1'b1; tick(20);
        check("ovf_drained", bus.rx_valid[1], 1'b0);

        // Glitch on channel 2
        uart_rx[2] = 1'b0; tick(10); uart_rx[2] = 1'b1; tick(400);
        check("glitch_no_char", pop_cyc[2] - start, lat);
        check("glitch_no_ferr", ferr_cnt[2], 0);

        // Framing error on channel 3, then recovery
        send_frame(3, 8'h55, 1'b0, 1'b0);
        tick(40);
        check("ferr_pulse", ferr_cnt[3], 1);
        check("ferr_no_push", bus.rx_valid[3], 1'b0);
        uart_rx[3] = 1'b1; tick(10);
        rx_exp.push_back({8'd3, 8'hA3});
        send_frame(3, 8'hA3, 1'b0, 1'b1);
        tick(20);

`ifdef SIM_UART_PARITY_EN
        rx_exp.push_back({8'd4, 8'h01});
        send_frame(4, 8'h01, 1'b0, 1'b1);
        tick(20);
        check("parity_err_pulse", perr_cnt[4], 1);
        tot = 0; for (int c = 0; c < 4; c++) tot += perr_cnt[c];
        check("parity_good_frames", tot, 0);
`else
        tot = 0; for (int c = 0; c < NCH; c++) tot += perr_cnt[c];
        check("parity_tied_low", tot, 0);
`endif

        for (int i = 0; i < 2000 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) tick;
        check("rx_scoreboard_empty", rx_exp.size(), 0);
        check("tx_scoreboard_empty", tx_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sim_uart_bank.md
Name: sim_uart_bank

Overview:
- Parametrised multi-channel virtual UART device for the simulation top level.
- Replaces the fixed single-channel serial DPI hookup with N independent channels, one per system UART.
- Each channel deserialises the DUT's TX line into a first-word-fall-through FIFO presented on a valid/ready byte stream.
- Each channel serialises host-supplied bytes onto the DUT's RX line.

Parameters:
NumChannels, 5, number of independent UART channels
ClockFrequency, 30_000_000, clk_i frequency in Hz
BaudRate, 921_600, line rate in bit/s, common to all channels
DataBits, 8, data bits per character (5..9)
RxFifoDepth, 8, RX FIFO entries per channel (power of two, >=2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
uart_rx_i  input  [NumChannels]  serial lines driven by the DUT (DUT TX)
uart_tx_o  output  [NumChannels]  serial lines driving the DUT (DUT RX)
rx_data_o  output  [NumChannels][DataBits]  head of RX FIFO
rx_valid_o  output  [NumChannels]  RX FIFO not empty
rx_ready_i  input  [NumChannels]  host pops head on valid&ready
tx_data_i  input  [NumChannels][DataBits]  byte to transmit
tx_valid_i  input  [NumChannels]  transmit request
tx_ready_o  output  [NumChannels]  serialiser idle, byte accepted on valid&ready
rx_overflow_o  output  [NumChannels]  1-cycle pulse, received char dropped (FIFO full)
rx_frame_err_o  output  [NumChannels]  1-cycle pulse, stop bit sampled low
rx_parity_err_o  output  [NumChannels]  1-cycle pulse, parity mismatch (0 without feature)

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: uart_tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, all error pulses 0, FIFOs empty, all FSMs IDLE.
- Bit timing:
  - ClocksPerBit = ClockFrequency/BaudRate (integer division); defaults give 32.
  - Elaboration error if ClocksPerBit < 4.
  - Bit counter width $clog2(ClocksPerBit).
- RX path:
  - uart_rx_i passes through a 2-flop synchroniser, reset value 1.
  - FSM states: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_IDLE.
  - IDLE->START on synchronised high-to-low transition.
  - START: sample at ClocksPerBit/2. If high, treat as a glitch and return to IDLE; if low, go to DATA.
  - DATA: sample every ClocksPerBit cycles thereafter, LSB first, DataBits samples.
  - STOP, stop bit sampled high: push character into FIFO in that cycle; go to IDLE.
  - STOP, stop bit sampled low: pulse rx_frame_err_o, discard character, go to WAIT_IDLE. WAIT_IDLE->IDLE once the line is sampled high.
  - Push while full and no pop in the same cycle: character dropped, rx_overflow_o pulses. Push and pop in the same cycle when full: both succeed, no overflow.
  - FIFO is first-word fall-through: rx_valid_o rises the cycle after the push.
  - rx_data_o holds the head while valid and ready is low.
- TX path:
  - FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - tx_ready_o=1 only in IDLE; the handshake latches tx_data_i.
  - uart_tx_o drives the start bit (0) from the cycle after the handshake.
  - Each bit is held exactly ClocksPerBit cycles, LSB first, followed by one stop bit (1).
  - tx_ready_o reasserts on the final cycle of the stop bit, enabling back-to-back frames with no gap.
  - tx_valid_i while not ready is ignored (no queuing).
- Channels are fully independent; no shared state other than the parameters.
- Reset mid-frame: outputs return to reset values immediately (async); any partial RX character is lost.

Optional Feature:
- Macro: SIM_UART_PARITY_EN.
- Defined:
  - An even parity bit is sent after the data bits and checked on receive.
  - On mismatch, rx_parity_err_o pulses in the parity-sample cycle; the character is still pushed (host decides).
  - Frame length = 1 start + DataBits + 1 parity + 1 stop bits.
- Undefined: no PARITY state, rx_parity_err_o tied 0, frame length = 1 start + DataBits + 1 stop bits.

Decomposition:
- Package sim_uart_pkg:
  - rx_state_e and tx_state_e enums;
  - clocks_per_bit() function;
  - DefaultBaud and DefaultFreq constants.
- Sub-module sim_uart_chan: one RX FSM, TX FSM and FIFO; generated NumChannels times by sim_uart_bank.

Test Plan:
- Reset: hold rst_ni=0 for 5 cycles with uart_rx_i=0 -> uart_tx_o=1, tx_ready_o=1, rx_valid_o=0; release -> no spurious character.
- TX: channel 0 tx_data_i=8'hA5 handshake -> uart_tx_o low next cycle; bits 1,0,1,0,0,1,0,1, then stop, each 32 cycles; tx_ready_o back after 320 cycles.
- RX: drive frame 8'h3C on channel 2 at 32 clk/bit -> rx_valid_o[2]=1 with rx_data_o=8'h3C within 3 cycles of mid-stop; other channels stay idle.
- Overflow: 9 frames into channel 1 with rx_ready_i=0 -> 8 entries retained in order, rx_overflow_o[1] pulses once; pop-during-push at full -> no pulse.
- Glitch and framing: 10-cycle low glitch -> no character. Frame with stop=0 -> rx_frame_err_o pulse, no push, recovery after line goes high.
- Parity (SIM_UART_PARITY_EN): send 8'h01 with parity bit 0 -> rx_parity_err_o pulse, data still delivered; TX of 8'h03 emits parity 0.
